// File: rtl/conv_layer_sequencer_pkg.sv
// Shared definitions for the conv-layer sequencer, compute processor and RAM wrappers.
package conv_layer_sequencer_pkg;

  localparam int unsigned DEF_DATASET_DEPTH_COUNTER_BITS = 9;
  localparam int unsigned DEF_FILTER_COUNTER_BITS        = 3;
  localparam int unsigned DEF_DRAIN_CYCLES               = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } seq_state_t;

  localparam logic [1:0] MUL_ALL = 2'b11;
  localparam logic [1:0] MUL_OFF = 2'b00;

endpackage

// File: rtl/conv_layer_sequencer_if.sv
// Control/issue bundle between the layer controller, the sequencer and the compute datapath.
interface conv_layer_sequencer_if
  import conv_layer_sequencer_pkg::*;
#(
  parameter int unsigned Dataset_depth_counter_bits = DEF_DATASET_DEPTH_COUNTER_BITS,
  parameter int unsigned Filter_counter_bits        = DEF_FILTER_COUNTER_BITS
);

  logic                                  Start;
  logic                                  Hold;
  logic [Filter_counter_bits-1:0]        Num_filters_m1;
  logic [Dataset_depth_counter_bits-1:0] Data_length_m1;
  logic [Dataset_depth_counter_bits-1:0] Data_RAM_address;
  logic                                  Data_RAM_Read_Enable;
  logic [Filter_counter_bits-1:0]        Weights_RAM_address_depth;
  logic                                  Weights_RAM_Read_Enable;
  logic [1:0]                            MUL_Enable;
  logic                                  ADD_Enable;
  logic                                  Busy;
  logic                                  Done;

  // Sequencer side
  modport master (
    input  Start, Hold, Num_filters_m1, Data_length_m1,
    output Data_RAM_address, Data_RAM_Read_Enable,
           Weights_RAM_address_depth, Weights_RAM_Read_Enable,
           MUL_Enable, ADD_Enable, Busy, Done
  );

  // Controller / datapath side
  modport slave (
    output Start, Hold, Num_filters_m1, Data_length_m1,
    input  Data_RAM_address, Data_RAM_Read_Enable,
           Weights_RAM_address_depth, Weights_RAM_Read_Enable,
           MUL_Enable, ADD_Enable, Busy, Done
  );

endinterface

// File: rtl/conv_layer_sequencer_loop_counter.sv
// Wrap counter: advances on inc, returns to zero after reaching limit.
module loop_counter #(
  parameter int unsigned Width = 3
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [Width-1:0] limit,
  output logic [Width-1:0] value,
  output logic             wrap
);

  // wrap is qualified by inc so chained counters only step on a real increment
  assign wrap = inc && (value == limit);

  // Counter register; compares against limit before incrementing, so never overflows
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= wrap ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Issue sequencer for the conv-layer pipeline: walks (position, filter) pairs,
// strobes the RAM reads and lines up MUL/ADD enables one cycle behind each issue.
module conv_layer_sequencer
  import conv_layer_sequencer_pkg::*;
#(
  parameter int unsigned Dataset_depth_counter_bits = DEF_DATASET_DEPTH_COUNTER_BITS,
  parameter int unsigned Filter_counter_bits        = DEF_FILTER_COUNTER_BITS,
  parameter int unsigned Drain_cycles               = DEF_DRAIN_CYCLES
) (
  input logic                    Clk,
  input logic                    Rst_n,
  conv_layer_sequencer_if.master bus
);

  localparam int unsigned DrainCntBits = $clog2(Drain_cycles + 2);
  localparam logic [DrainCntBits-1:0] DrainLast = DrainCntBits'(Drain_cycles);

  seq_state_t state_q, state_d;

  logic [Filter_counter_bits-1:0]        nf_lim_q;
  logic [Dataset_depth_counter_bits-1:0] dl_lim_q;
  logic [DrainCntBits-1:0]               drain_q;

  logic                                  start_acc;
  logic                                  issue;
  logic [Filter_counter_bits-1:0]        f_val;
  logic [Dataset_depth_counter_bits-1:0] p_val;
  logic                                  f_wrap;
  logic                                  p_wrap;

  logic                                  rd_en_q;
  logic [Dataset_depth_counter_bits-1:0] p_addr_q;
  logic [Filter_counter_bits-1:0]        f_addr_q;
  logic                                  add_en_q;
  logic [1:0]                            mul_en_q;
  logic                                  busy_q;
  logic                                  done_q;

  // Start is only honoured when no layer is in flight (DONE counts as finished)
  assign start_acc = bus.Start && ((state_q == IDLE) || (state_q == DONE));
  assign issue     = (state_q == RUN) && !bus.Hold;

  // Filter index is the inner loop; its wrap steps the position index
  loop_counter #(.Width(Filter_counter_bits)) u_filter_cnt (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .clr   (start_acc),
    .inc   (issue),
    .limit (nf_lim_q),
    .value (f_val),
    .wrap  (f_wrap)
  );

  loop_counter #(.Width(Dataset_depth_counter_bits)) u_pos_cnt (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .clr   (start_acc),
    .inc   (f_wrap),
    .limit (dl_lim_q),
    .value (p_val),
    .wrap  (p_wrap)
  );

  // State register and configuration latch
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      nf_lim_q <= '0;
      dl_lim_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        nf_lim_q <= bus.Num_filters_m1;
        dl_lim_q <= bus.Data_length_m1;
      end
    end
  end

  // Next-state decode; p_wrap marks the final (last position, last filter) issue
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_acc) state_d = RUN;
      RUN:     if (p_wrap) state_d = DRAIN;
      DRAIN:   if (drain_q == DrainLast) state_d = DONE;
      DONE:    state_d = start_acc ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Drain timer: one cycle of enable lag plus the datapath flush
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      drain_q <= '0;
    end else if (state_q == DRAIN) begin
      drain_q <= drain_q + 1'b1;
    end else begin
      drain_q <= '0;
    end
  end

  // Registered outputs; Busy/Done trail the state by one register like the issue strobes
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rd_en_q  <= 1'b0;
      p_addr_q <= '0;
      f_addr_q <= '0;
      add_en_q <= 1'b0;
      mul_en_q <= MUL_OFF;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rd_en_q <= issue;
      if (issue) begin
        p_addr_q <= p_val;
        f_addr_q <= f_val;
      end
      add_en_q <= rd_en_q;
      mul_en_q <= rd_en_q ? MUL_ALL : MUL_OFF;
      busy_q   <= (state_q == RUN) || (state_q == DRAIN);
      done_q   <= (state_q == DONE);
    end
  end

  assign bus.Data_RAM_Read_Enable      = rd_en_q;
  assign bus.Weights_RAM_Read_Enable   = rd_en_q;
  assign bus.Data_RAM_address          = p_addr_q;
  assign bus.Weights_RAM_address_depth = f_addr_q;
  assign bus.ADD_Enable                = add_en_q;
  assign bus.MUL_Enable                = mul_en_q;
  assign bus.Busy                      = busy_q;
  assign bus.Done                      = done_q;

endmodule
